dec_counter_ctrl: RTL

Command sequencer for the decimal counter datapath (count, overflow). It accepts CLEAR, LOAD and RUN commands over a valid/ready handshake and drives the counter's clear, load and increment strobes. It tracks wrap-around overflows during a RUN and reports completion, final count and status to the issuing agent. It sits between a host/testbench requester and one decimal counter instance.

---
 rtl/dec_counter_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dec_counter_ctrl.sv
// Command sequencer for a wrapping decimal counter: accepts CLEAR/LOAD/RUN over
// valid/ready, strobes the counter, tallies wrap-arounds and reports completion.
module dec_counter_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MAX_COUNT = 99,
    parameter int OVF_W     = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             halt,
    output logic             cnt_clear,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             cnt_inc,
    input  logic [WIDTH-1:0] cnt_count,
    input  logic             cnt_overflow,
    output logic             done,
    output logic [1:0]       done_status,
    output logic [WIDTH-1:0] done_count,
    output logic [OVF_W-1:0] done_ovf,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_WAIT, S_DONE
    } state_t;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ABORTED = 2'b01;
    localparam logic [1:0] ST_BADARG  = 2'b10;
    localparam logic [1:0] ST_BADOP   = 2'b11;

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

    state_t           state, state_nx;
    logic [WIDTH-1:0] arg_q;
    logic [WIDTH-1:0] remaining;
    logic             ready_q;
    logic             accept;

    assign accept = cmd_valid && ready_q;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_CLEAR: state_nx = S_CLEAR;
                        OP_LOAD:  state_nx = (cmd_arg > MAXV) ? S_DONE : S_LOAD;
                        OP_RUN:   state_nx = (cmd_arg == '0) ? S_DONE : S_RUN;
                        default:  state_nx = S_DONE;
                    endcase
                end
            end
            S_CLEAR, S_LOAD: state_nx = S_WAIT;
            S_RUN: begin
                if (halt || remaining == WIDTH'(1))
                    state_nx = S_WAIT;
            end
            S_WAIT:  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // ready is a flop so it stays low through reset and rises one edge later
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            ready_q     <= 1'b0;
            arg_q       <= '0;
            remaining   <= '0;
            done_status <= ST_OK;
            done_count  <= '0;
            done_ovf    <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx == S_IDLE);
            if (accept) begin
                arg_q      <= cmd_arg;
                remaining  <= cmd_arg;
                done_ovf   <= '0;
                done_count <= cnt_count;
                if (cmd_op == 2'b11)
                    done_status <= ST_BADOP;
                else if (cmd_op == OP_LOAD && cmd_arg > MAXV)
                    done_status <= ST_BADARG;
                else
                    done_status <= ST_OK;
            end else begin
                if (state == S_RUN && !halt)
                    remaining <= remaining - WIDTH'(1);
                if (state == S_RUN && halt)
                    done_status <= ST_ABORTED;
                if ((state == S_RUN || state == S_WAIT) && cnt_overflow && done_ovf != '1)
                    done_ovf <= done_ovf + OVF_W'(1);
                if (state == S_WAIT)
                    done_count <= cnt_count;
            end
        end
    end

    // halt suppresses the increment in the same cycle, hence the direct gating
    assign cmd_ready    = ready_q;
    assign busy         = (state != S_IDLE);
    assign cnt_clear    = (state == S_CLEAR);
    assign cnt_load     = (state == S_LOAD);
    assign cnt_load_val = (state == S_LOAD) ? arg_q : '0;
    assign cnt_inc      = (state == S_RUN) && !halt;
    assign done         = (state == S_DONE);

endmodule
